// File: rtl/cs_pkg.sv
// Shared helpers for the CS window filter: clog2, default-config widths and the Xappr mode enum.
// Included by cs_appr_select and cs_window_param; rounding option CS_ROUND_EN lives in the top.
package cs_pkg;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

  function automatic int sum_w(input int data_w, input int depth);
    return data_w + clog2(depth);
  endfunction

  localparam int CS_DATA_W = 8;
  localparam int CS_DEPTH  = 9;
  localparam int SUM_W     = CS_DATA_W + clog2(CS_DEPTH);
  localparam int ACC_W     = SUM_W + 1;

  typedef enum logic {
    CS_BELOW = 1'b0,
    CS_ABOVE = 1'b1
  } cs_mode_e;

endpackage

// File: rtl/cs_appr_select.sv
// Combinational Xappr picker: window sample nearest the mean, from below (max of Xi*DEPTH<=sum)
// or from above (min of Xi*DEPTH>=sum); zero latency, no flow control.
module cs_appr_select
  import cs_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 9,
  parameter int SUM_W  = 12
) (
  input  logic [DEPTH-1:0][DATA_W-1:0] win_i,
  input  logic [SUM_W-1:0]             sum_i,
  input  cs_mode_e                     mode_i,
  output logic [DATA_W-1:0]            xappr_o
);

  localparam int LVLS = clog2(DEPTH);
  localparam int NP   = 1 << LVLS;
  localparam logic [SUM_W-1:0] DEPTH_W = SUM_W'(DEPTH);

  logic [NP-1:0]             cand;
  logic [NP-1:0][DATA_W-1:0] val;
  logic [SUM_W-1:0]          prod;
  logic                      take_b;
  logic                      any_v;

  always_comb begin
    cand   = '0;
    val    = '0;
    prod   = '0;
    take_b = 1'b0;
    any_v  = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      prod    = SUM_W'(win_i[i]) * DEPTH_W;
      cand[i] = (mode_i == CS_BELOW) ? (prod <= sum_i) : (prod >= sum_i);
      val[i]  = win_i[i];
    end
    // Pairwise tree, folded in place; padding leaves stay non-candidates.
    for (int l = 0; l < LVLS; l++) begin
      for (int j = 0; j < (NP >> (l + 1)); j++) begin
        take_b = cand[2*j+1] && (!cand[2*j] ||
                 ((mode_i == CS_BELOW) ? (val[2*j+1] > val[2*j]) : (val[2*j+1] < val[2*j])));
        any_v  = cand[2*j] | cand[2*j+1];
        val[j]  = take_b ? val[2*j+1] : val[2*j];
        cand[j] = any_v;
      end
    end
    xappr_o = val[0];
  end

endmodule

// File: rtl/cs_window_param.sv
// Sliding-window CS filter, y = (sum + DEPTH*Xappr) >> SHIFT, one cycle after each accepted sample
// once full; no backpressure (in_valid only). Define CS_ROUND_EN for round-half-up instead of truncation.
module cs_window_param
  import cs_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 9,
  parameter int SHIFT  = 3,
  parameter int OUT_W  = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              mode,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] x,
  output logic [OUT_W-1:0]  y,
  output logic              out_valid,
  output logic              full
);

  localparam int W_SUM  = sum_w(DATA_W, DEPTH);
  localparam int W_ACC  = W_SUM + 1;
  localparam int W_RND  = W_ACC + 1;
  localparam int W_FILL = clog2(DEPTH + 1);
  localparam longint HALF_L = (SHIFT > 0) ? (longint'(1) << (SHIFT - 1)) : 64'sd0;
  localparam longint MAX_Y  = ((((longint'(1) << DATA_W) - 1) * 2 * DEPTH) + HALF_L) >> SHIFT;

  if (DEPTH < 2) begin : g_bad_depth
    $error("cs_window_param: DEPTH must be at least 2");
  end
  if (MAX_Y >= (longint'(1) << OUT_W)) begin : g_bad_out_w
    $error("cs_window_param: OUT_W too narrow for the largest result");
  end

  logic [DEPTH-1:0][DATA_W-1:0] win_q, win_d;
  logic [W_SUM-1:0]             sum_q, sum_d;
  logic [W_FILL-1:0]            fill_q, fill_d;
  logic                         s1_vld_q, s1_vld_d;
  logic [OUT_W-1:0]             y_q, y_d;
  logic                         ov_q, ov_d;
  logic                         full_w;
  logic [DATA_W-1:0]            xappr;
  logic [W_ACC-1:0]             acc;
  logic [W_RND-1:0]             acc_r;
  logic [OUT_W-1:0]             y_next;

  assign full_w = (fill_q == W_FILL'(DEPTH));

  cs_appr_select #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .SUM_W  (W_SUM)
  ) u_appr_select (
    .win_i   (win_q),
    .sum_i   (sum_q),
    .mode_i  (cs_mode_e'(mode)),
    .xappr_o (xappr)
  );

  always_comb begin
    acc = W_ACC'(sum_q) + W_ACC'(xappr) * W_ACC'(DEPTH);
`ifdef CS_ROUND_EN
    acc_r = W_RND'(acc) + W_RND'(HALF_L);
`else
    acc_r = W_RND'(acc);
`endif
    y_next = OUT_W'(acc_r >> SHIFT);
  end

  always_comb begin
    win_d    = win_q;
    sum_d    = sum_q;
    fill_d   = fill_q;
    s1_vld_d = 1'b0;
    y_d      = y_q;
    ov_d     = 1'b0;
    if (clear) begin
      win_d  = '0;
      sum_d  = '0;
      fill_d = '0;
    end else begin
      if (in_valid) begin
        win_d    = {win_q[DEPTH-2:0], x};
        sum_d    = sum_q + W_SUM'(x) - W_SUM'(win_q[DEPTH-1]);
        s1_vld_d = 1'b1;
        if (!full_w) fill_d = fill_q + W_FILL'(1);
      end
      // Stage 2 sees the window left by the previous edge's sample.
      if (s1_vld_q && full_w) begin
        ov_d = 1'b1;
        y_d  = y_next;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      win_q    <= '0;
      sum_q    <= '0;
      fill_q   <= '0;
      s1_vld_q <= 1'b0;
      y_q      <= '0;
      ov_q     <= 1'b0;
    end else begin
      win_q    <= win_d;
      sum_q    <= sum_d;
      fill_q   <= fill_d;
      s1_vld_q <= s1_vld_d;
      y_q      <= y_d;
      ov_q     <= ov_d;
    end
  end

  assign y         = y_q;
  assign out_valid = ov_q;
  assign full      = full_w;

endmodule

// File: tb/tb_cs_window_param.sv
// Directed bench for cs_window_param: vector table on the default build plus gapped streams
// checked against a division-based reference on the default and a DEPTH=5/DATA_W=12 instance.
module tb_cs_window_param;

`ifdef CS_ROUND_EN
  localparam bit RND_EN = 1'b1;
`else
  localparam bit RND_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rst_b = 1'b0;
  logic        clr = 1'b0;
  logic        mode = 1'b0;
  logic        vld = 1'b0;
  logic [7:0]  xa = '0;
  logic [11:0] xb = '0;
  logic [9:0]  ya;
  logic [14:0] yb;
  logic        ova, fulla, ovb, fullb;

  always #5 clk = ~clk;

  cs_window_param #(.DATA_W(8), .DEPTH(9), .SHIFT(3), .OUT_W(10)) dut_a (
    .clk(clk), .reset(rst_n), .clear(clr), .mode(mode), .in_valid(vld),
    .x(xa), .y(ya), .out_valid(ova), .full(fulla)
  );

  cs_window_param #(.DATA_W(12), .DEPTH(5), .SHIFT(2), .OUT_W(15)) dut_b (
    .clk(clk), .reset(rst_b), .clear(clr), .mode(mode), .in_valid(vld),
    .x(xb), .y(yb), .out_valid(ovb), .full(fullb)
  );

  typedef struct {
    bit rst_n;
    bit clr;
    bit mode;
    bit vld;
    int x;
    bit e_ov;
    bit e_full;
    int e_y;
  } vec_t;

  vec_t tbl[$];
  int   n_vec = 0;
  int   n_bad = 0;

  task automatic add(input bit r, input bit c, input bit m, input bit v, input int xv,
                     input bit eo, input bit ef, input int ey);
    vec_t t;
    t.rst_n = r; t.clr = c; t.mode = m; t.vld = v; t.x = xv;
    t.e_ov = eo; t.e_full = ef; t.e_y = ey;
    tbl.push_back(t);
  endtask

  task automatic chk(input string nm, input int idx, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s[%0d]: got %0d, expected %0d", nm, idx, act, exp);
    end
  endtask

  function automatic int model_y(input int q[$], input int depth, input int shift, input bit md);
    int s, t, best, r;
    s = 0;
    foreach (q[i]) s += q[i];
    if (!md) begin
      t = s / depth;
      best = -1;
      foreach (q[i]) if (q[i] <= t && q[i] > best) best = q[i];
    end else begin
      t = (s + depth - 1) / depth;
      best = 1 << 30;
      foreach (q[i]) if (q[i] >= t && q[i] < best) best = q[i];
    end
    r = RND_EN ? (1 << (shift - 1)) : 0;
    return (s + depth * best + r) >> shift;
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int y13, y12, y573, y14;
    int qa[$];
    int qb[$];
    int hold_a, hold_b, va, vb;
    bit m, ea, eb;

    y13  = RND_EN ? 14 : 13;
    y12  = RND_EN ? 13 : 12;
    y573 = RND_EN ? 574 : 573;
    y14  = RND_EN ? 15 : 14;

    // Reset state, fill with 1..9, slide in 10.
    add(0, 0, 0, 0, 0, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 1; i <= 8; i++) add(1, 0, 0, 1, i, 0, 0, 0);
    add(1, 0, 0, 1, 9, 0, 1, 0);
    add(1, 0, 0, 1, 10, 1, 1, 11);
    add(1, 0, 0, 0, 0, 1, 1, y13);
    add(1, 0, 0, 0, 0, 0, 1, y13);
    // Mode compare on {0 x8, 10}; second result uses mode=1 sampled at its own edge.
    add(1, 1, 0, 1, 99, 0, 0, y13);
    for (int i = 0; i < 8; i++) add(1, 0, 0, 1, 0, 0, 0, y13);
    add(1, 0, 0, 1, 10, 0, 1, y13);
    add(1, 0, 0, 1, 0, 1, 1, 1);
    add(1, 0, 1, 0, 0, 1, 1, y12);
    add(1, 0, 1, 0, 0, 0, 1, y12);
    // All-max window.
    add(1, 1, 0, 0, 0, 0, 0, y12);
    for (int i = 0; i < 8; i++) add(1, 0, 0, 1, 255, 0, 0, y12);
    add(1, 0, 0, 1, 255, 0, 1, y12);
    add(1, 0, 0, 0, 0, 1, 1, y573);
    // Clear with a sample after 5 samples: sample dropped, 9 fresh samples needed.
    add(1, 1, 0, 0, 0, 0, 0, y573);
    for (int i = 0; i < 5; i++) add(1, 0, 0, 1, 255, 0, 0, y573);
    add(1, 1, 0, 1, 7, 0, 0, y573);
    for (int i = 0; i < 8; i++) add(1, 0, 0, 1, 8, 0, 0, y573);
    add(1, 0, 0, 1, 8, 0, 1, y573);
    add(1, 0, 0, 0, 0, 1, 1, 18);
    // Reset (with clear also high) mid-fill, then mode=1 on {0 x5, 9 x4}.
    add(1, 1, 0, 0, 0, 0, 0, 18);
    for (int i = 0; i < 4; i++) add(1, 0, 0, 1, 50, 0, 0, 18);
    add(0, 1, 0, 1, 60, 0, 0, 0);
    for (int i = 0; i < 5; i++) add(1, 0, 1, 1, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) add(1, 0, 1, 1, 9, 0, 0, 0);
    add(1, 0, 1, 1, 9, 0, 1, 0);
    add(1, 0, 1, 0, 0, 1, 1, y14);
    add(1, 0, 1, 0, 0, 0, 1, y14);

    for (int i = 0; i < tbl.size(); i++) begin
      @(negedge clk);
      rst_n = tbl[i].rst_n;
      clr   = tbl[i].clr;
      mode  = tbl[i].mode;
      vld   = tbl[i].vld;
      xa    = 8'(tbl[i].x);
      @(posedge clk);
      #1;
      chk("out_valid", i, int'(ova), int'(tbl[i].e_ov));
      chk("full", i, int'(fulla), int'(tbl[i].e_full));
      chk("y", i, int'(ya), tbl[i].e_y);
    end

    // Gapped streams on both instances against the gap-free model.
    @(negedge clk);
    rst_n = 1'b0; rst_b = 1'b0; clr = 1'b0; vld = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_a_y", 0, int'(ya), 0);
    chk("rst_b_y", 0, int'(yb), 0);
    chk("rst_b_ov", 0, int'(ovb), 0);
    chk("rst_b_full", 0, int'(fullb), 0);
    @(negedge clk);
    rst_n = 1'b1; rst_b = 1'b1;
    hold_a = 0;
    hold_b = 0;
    for (int k = 0; k < 16; k++) begin
      m  = 1'($urandom_range(0, 1));
      va = (k % 5 == 3) ? 255 : int'($urandom_range(0, 255));
      vb = (k % 5 == 3) ? 4095 : int'($urandom_range(0, 4095));
      @(negedge clk);
      vld = 1'b1; xa = 8'(va); xb = 12'(vb); mode = !m;
      @(posedge clk);
      #1;
      chk("gap_ov_a_s", k, int'(ova), 0);
      chk("gap_ov_b_s", k, int'(ovb), 0);
      chk("gap_full_a", k, int'(fulla), int'(k + 1 >= 9));
      chk("gap_full_b", k, int'(fullb), int'(k + 1 >= 5));
      qa.push_back(va);
      qb.push_back(vb);
      if (qa.size() > 9) void'(qa.pop_front());
      if (qb.size() > 5) void'(qb.pop_front());
      ea = (k + 1 >= 9);
      eb = (k + 1 >= 5);
      if (ea) hold_a = model_y(qa, 9, 3, m);
      if (eb) hold_b = model_y(qb, 5, 2, m);
      @(negedge clk);
      vld = 1'b0; mode = m;
      @(posedge clk);
      #1;
      chk("gap_ov_a", k, int'(ova), int'(ea));
      chk("gap_ov_b", k, int'(ovb), int'(eb));
      chk("gap_y_a", k, int'(ya), hold_a);
      chk("gap_y_b", k, int'(yb), hold_b);
      for (int g = 0; g < 2; g++) begin
        @(negedge clk);
        @(posedge clk);
        #1;
        chk("hold_ov_a", k, int'(ova), 0);
        chk("hold_ov_b", k, int'(ovb), 0);
        chk("hold_y_a", k, int'(ya), hold_a);
        chk("hold_y_b", k, int'(yb), hold_b);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/cs_window_param.md
Name: cs_window_param

Overview:
- Parametrised successor of the 9-sample CS filter. Keeps a sliding window of the last DEPTH input samples.
- For each window it computes the approximate mean Xappr: the window sample nearest the average, taken from below or from above depending on mode.
- Output: Y = (sum + DEPTH*Xappr) >> SHIFT.
- Adds an input valid/output valid handshake, a window-fill tracker, a synchronous clear and a runtime mode select. Sits between the sample source and downstream scoring logic.

Parameters:
- DATA_W, 8, width of each input sample (unsigned).
- DEPTH, 9, number of samples in the window (>=2).
- SHIFT, 3, right-shift applied to (sum + DEPTH*Xappr).
- OUT_W, 10, output width. It must hold ((2^DATA_W-1)*2*DEPTH + 2^(SHIFT-1)) >> SHIFT; elaboration fails otherwise.

Ports:
- clk  in  1  single clock, all logic on posedge.
- reset  in  1  synchronous, active-low reset.
- clear  in  1  synchronous window flush.
- mode  in  1  0 = Xappr from below, 1 = Xappr from above.
- in_valid  in  1  x is a new sample this cycle.
- x  in  DATA_W  unsigned sample.
- y  out  OUT_W  filter result.
- out_valid  out  1  y holds a result for a full window.
- full  out  1  window holds DEPTH valid samples.

Behaviour:
- Reset (reset==0 at posedge):
  - Window registers, running sum and fill count all go to 0.
  - y=0, out_valid=0, full=0.
  - Reset mid-operation discards all samples; after release, the first result needs DEPTH new samples.
- Stage 1, at a posedge with in_valid=1:
  - Window shifts; x enters, the oldest sample leaves.
  - sum_next = sum + x - oldest. Width SUM_W = DATA_W + clog2(DEPTH); never overflows.
  - Fill count increments and saturates at DEPTH; full = (fill==DEPTH).
- Stage 2, combinational from the stage-1 registers, registered at the next posedge:
  - mode 0: Xappr = largest Xi with Xi*DEPTH <= sum. This is equivalent to Xi <= floor(sum/DEPTH); no divider is used. A candidate always exists (the window minimum).
  - mode 1: Xappr = smallest Xi with Xi*DEPTH >= sum. A candidate always exists (the window maximum).
  - Ties (duplicate values) give the same value, so tie order is irrelevant.
  - y_next = (sum + DEPTH*Xappr) >> SHIFT. Intermediate width is SUM_W+1; the result is truncated unless CS_ROUND_EN is defined.
- Latency and handshake:
  - out_valid rises on the posedge after the sample that makes the window full. Sample at edge t gives y/out_valid at edge t+1.
  - out_valid stays 1 for exactly one cycle per accepted sample while full. Cycles with in_valid=0 produce out_valid=0, and y holds its last value.
  - mode is sampled at the stage-2 edge; a change affects only results registered after it.
- clear:
  - At a posedge, resets the window, sum and fill count to 0, and sets out_valid=0 on the same edge.
  - y holds its last value.
  - If clear and in_valid are both 1, clear wins and the sample is dropped.
  - reset has priority over clear.
- Startup: before full, no result is produced and the window registers still contain zeros.

Optional Feature:
- Macro: CS_ROUND_EN.
- Defined: y_next = (sum + DEPTH*Xappr + 2^(SHIFT-1)) >> SHIFT, i.e. round half up.
- Undefined: plain truncation, giving results bit-exact with the legacy 9-sample filter for DEPTH=9, SHIFT=3, mode=0.

Decomposition:
- Package cs_pkg holds:
  - the function clog2;
  - the localparams SUM_W and ACC_W = SUM_W+1;
  - the mode enum (CS_BELOW=0, CS_ABOVE=1).
- One sub-module, cs_appr_select: combinational. Inputs are the window array, sum and mode; it does the DEPTH parallel compares Xi*DEPTH vs sum and a max/min reduction tree, returning Xappr.
- The top level holds the window, running sum, fill counter, clear/reset logic and output register.

Test Plan:
- Fill and mode 0: after reset, feed 1..9 with mode=0 → first out_valid after the 9th sample. sum=45, Xappr=5, y=90>>3=11 (0x00B); 11 with CS_ROUND_EN.
- Slide: then feed 10 → window 2..10, sum=54, Xappr=6, y=13; 14 with CS_ROUND_EN. out_valid=1 for one cycle per sample.
- Mode compare: feed 0,0,0,0,0,0,0,0,10.
  - mode 0: Xappr=0, y=10>>3=1.
  - mode 1: Xappr=10, y=100>>3=12; 13 with CS_ROUND_EN.
- Max values: feed nine 255s → y=4590>>3=573 (0x23D); 574 with CS_ROUND_EN. No overflow.
- clear/reset mid-stream:
  - Assert clear together with in_valid after 5 samples → the sample is dropped, full=0, out_valid=0, and 9 new samples are required.
  - Repeat with reset=0 → y=0.
- Gaps and parameters:
  - Hold in_valid=0 for 3 cycles between samples → out_valid=0 and y holds during the gap; results match a gap-free reference model.
  - Rerun with DEPTH=5, DATA_W=12, SHIFT=2, OUT_W=15 against the same model.
